// File: rtl/camera_exposure_ctrl.sv
// Exposure/readout sequencer for a small pixel array.
// It holds an adjustable exposure count and drives the erase, expose, row-read and ADC strobes.
module camera_exposure_ctrl (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Init,
    input  logic       Exp_increase,
    input  logic       Exp_decrease,
    input  logic       Ovf5,
    output logic       Start,
    output logic [4:0] Initial,
    output logic       Erase,
    output logic       Expose,
    output logic       NRE_1,
    output logic       NRE_2,
    output logic       ADC
);

    typedef enum logic [1:0] {
        IDLE,
        EXPOSE,
        READOUT
    } state_t;

    localparam logic [4:0] EXP_MIN = 5'd2;
    localparam logic [4:0] EXP_MAX = 5'd30;

    state_t     state, state_next;
    logic [4:0] exp_reg, exp_next;
    logic [4:0] initial_reg, initial_next;
    logic [2:0] step, step_next;
    logic       start_reg, start_next;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            exp_reg     <= EXP_MIN;
            initial_reg <= EXP_MIN;
            step        <= 3'd0;
            start_reg   <= 1'b0;
        end else begin
            state       <= state_next;
            exp_reg     <= exp_next;
            initial_reg <= initial_next;
            step        <= step_next;
            start_reg   <= start_next;
        end
    end

    // start_reg marks the first EXPOSE cycle; an Ovf5 seen then is stale and ignored.
    always_comb begin
        state_next   = state;
        exp_next     = exp_reg;
        initial_next = initial_reg;
        step_next    = step;
        start_next   = 1'b0;
        case (state)
            IDLE: begin
                if (Init) begin
                    state_next   = EXPOSE;
                    initial_next = exp_reg;
                    start_next   = 1'b1;
                end else if (Exp_increase && !Exp_decrease) begin
                    if (exp_reg < EXP_MAX) exp_next = exp_reg + 5'd1;
                end else if (Exp_decrease && !Exp_increase) begin
                    if (exp_reg > EXP_MIN) exp_next = exp_reg - 5'd1;
                end
            end
            EXPOSE: begin
                if (Ovf5 && !start_reg) begin
                    state_next = READOUT;
                    step_next  = 3'd0;
                end
            end
            READOUT: begin
                step_next = step + 3'd1;
                if (step == 3'd7) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode only registered state, so there is no input-to-output path.
    always_comb begin
        Start   = start_reg;
        Initial = initial_reg;
        Erase   = (state == IDLE);
        Expose  = (state == EXPOSE);
        NRE_1   = 1'b1;
        NRE_2   = 1'b1;
        ADC     = 1'b0;
        if (state == READOUT) begin
            NRE_1 = (step > 3'd2);
            NRE_2 = !((step >= 3'd4) && (step <= 3'd6));
            ADC   = (step == 3'd1) || (step == 3'd5);
        end
    end

endmodule
